// File: rtl/la_pkg.sv
// Shared constants and types for the logic-analyser sample path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package la_pkg;
    localparam int NUM_CHANNELS = 16;
    localparam int WORD_W       = 16;
    localparam int CHAN_IDX_W   = $clog2(NUM_CHANNELS);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of vec, plus a valid flag.
// Latency: combinational.
// Backpressure: none.
module lowest_set_bit #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    always_comb begin
        idx   = '0;
        valid = |vec;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/sample_packer.sv
// Captures a batch of channel words and serialises them lowest channel first.
// Latency: first word registered one edge after capture, then one word per clock.
// Backpressure: none; a batch arriving with >=2 words still pending is dropped and flagged.
module sample_packer #(
    parameter int NUM_CHANNELS = la_pkg::NUM_CHANNELS,
    parameter int WORD_W       = la_pkg::WORD_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             acq_enable,
    input  logic [NUM_CHANNELS-1:0]          channel_enable,
    input  logic [NUM_CHANNELS*WORD_W-1:0]   chan_data,
    input  logic [NUM_CHANNELS-1:0]          chan_ready,
    output logic [WORD_W-1:0]                sample_data,
    output logic                             sample_data_avail,
    output logic [$clog2(NUM_CHANNELS)-1:0]  sample_chan,
    output logic                             overrun
);
    import la_pkg::*;

    localparam int IDX_W = $clog2(NUM_CHANNELS);

    state_t                  state, state_nxt;
    logic [NUM_CHANNELS-1:0] pending, pending_nxt, pending_rest, cap;
    logic [WORD_W-1:0]       hold [NUM_CHANNELS];
    logic [IDX_W-1:0]        lsb_idx;
    logic                    lsb_vld;
    logic                    load, emit, ovr_set;

    lowest_set_bit #(.N(NUM_CHANNELS), .IDX_W(IDX_W)) u_lsb (
        .vec   (pending),
        .idx   (lsb_idx),
        .valid (lsb_vld)
    );

    assign cap          = acq_enable ? (chan_ready & channel_enable) : '0;
    assign pending_rest = pending & (pending - NUM_CHANNELS'(1));

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        load        = 1'b0;
        emit        = 1'b0;
        ovr_set     = 1'b0;
        case (state)
            IDLE: begin
                if (cap != '0) begin
                    load        = 1'b1;
                    pending_nxt = cap;
                    state_nxt   = EMIT;
                end
            end
            EMIT: begin
                emit        = lsb_vld;
                pending_nxt = pending_rest;
                // A new batch is only accepted on the cycle the last word leaves.
                if (cap != '0) begin
                    if (pending_rest == '0) begin
                        load        = 1'b1;
                        pending_nxt = cap;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end
                if (pending_nxt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            pending           <= '0;
            sample_data       <= '0;
            sample_chan       <= '0;
            sample_data_avail <= 1'b0;
            overrun           <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) hold[i] <= '0;
        end else begin
            state             <= state_nxt;
            pending           <= pending_nxt;
            sample_data_avail <= emit;
            if (emit) begin
                sample_data <= hold[lsb_idx];
                sample_chan <= lsb_idx;
            end
            if (load) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (cap[i]) hold[i] <= chan_data[i*WORD_W +: WORD_W];
                end
            end
            if (!acq_enable)  overrun <= 1'b0;
            else if (ovr_set) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: table-driven batches plus hand-written corner cases,
// with a scoreboard queue of expected {channel, word} pairs.
module tb_sample_packer;
    localparam int NC = 16;
    localparam int WW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              acq_enable;
    logic [NC-1:0]     channel_enable;
    logic [NC*WW-1:0]  chan_data;
    logic [NC-1:0]     chan_ready;
    logic [WW-1:0]     sample_data;
    logic              sample_data_avail;
    logic [3:0]        sample_chan;
    logic              overrun;

    sample_packer #(.NUM_CHANNELS(NC), .WORD_W(WW)) dut (
        .clk               (clk),
        .rst               (rst),
        .acq_enable        (acq_enable),
        .channel_enable    (channel_enable),
        .chan_data         (chan_data),
        .chan_ready        (chan_ready),
        .sample_data       (sample_data),
        .sample_data_avail (sample_data_avail),
        .sample_chan       (sample_chan),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [19:0] exp_q[$];

    typedef struct {
        logic [15:0] en;
        logic [15:0] rdy;
        logic [15:0] seed;
        int          n_words;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every emitted word must match the head of the expected queue.
    always @(negedge clk) begin
        if (sample_data_avail === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {12'h0, sample_chan, sample_data}, 32'hFFFFFFFF);
            end else begin
                chk("word", {12'h0, sample_chan, sample_data}, {12'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic set_data(input logic [15:0] seed);
        for (int i = 0; i < NC; i++) chan_data[i*WW +: WW] = seed + 16'(i);
    endtask

    task automatic push_exp(input logic [15:0] mask, input logic [15:0] seed, input int limit);
        int n = 0;
        for (int i = 0; i < NC; i++) begin
            if (mask[i] && n < limit) begin
                exp_q.push_back({4'(i), seed + 16'(i)});
                n++;
            end
        end
    endtask

    // Drives a one-cycle strobe; returns at the negedge just after the capture edge.
    task automatic drive_batch(input logic [15:0] en, input logic [15:0] rdy,
                               input logic [15:0] seed, input int push_limit);
        @(negedge clk);
        channel_enable = en;
        chan_ready     = rdy;
        set_data(seed);
        push_exp(en & rdy, seed, push_limit);
        @(negedge clk);
        chan_ready = '0;
    endtask

    initial begin
        int run;
        int b2b;

        tbl[0] = '{16'hFFFF, 16'hFFFF, 16'hA000, 16};
        tbl[1] = '{16'h8421, 16'hFFFF, 16'hB000, 4};
        tbl[2] = '{16'hFFFF, 16'h00F0, 16'hC000, 4};
        tbl[3] = '{16'h0000, 16'hFFFF, 16'hE000, 0};
        tbl[4] = '{16'hFFFF, 16'h8001, 16'hD000, 2};
        tbl[5] = '{16'h0F0F, 16'h0FF0, 16'h3000, 4};

        // Reset with random inputs
        rst = 1'b1;
        acq_enable = 1'b1;
        channel_enable = '1;
        chan_ready = '0;
        set_data(16'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_avail", {31'h0, sample_data_avail}, 32'h0);
            acq_enable     = 1'($urandom_range(0, 1));
            channel_enable = 16'($urandom);
            chan_ready     = 16'($urandom);
            set_data(16'($urandom));
        end
        chk("rst_data", {16'h0, sample_data}, 32'h0);
        chk("rst_chan", {28'h0, sample_chan}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        rst = 1'b0;
        acq_enable = 1'b1;
        chan_ready = '0;
        repeat (2) @(negedge clk);
        chk("post_rst_avail", {31'h0, sample_data_avail}, 32'h0);

        // Table-driven batches
        for (int t = 0; t < 6; t++) begin
            drive_batch(tbl[t].en, tbl[t].rdy, tbl[t].seed, NC);
            chk($sformatf("t%0d_lat0", t), {31'h0, sample_data_avail}, 32'h0);
            run = 0;
            for (int j = 0; j < tbl[t].n_words; j++) begin
                @(negedge clk);
                if (sample_data_avail === 1'b1) run++;
            end
            @(negedge clk);
            chk($sformatf("t%0d_tail", t), {31'h0, sample_data_avail}, 32'h0);
            chk($sformatf("t%0d_run", t), 32'(run), 32'(tbl[t].n_words));
            repeat (3) @(negedge clk);
            chk($sformatf("t%0d_overrun", t), {31'h0, overrun}, 32'h0);
            chk($sformatf("t%0d_drained", t), 32'(exp_q.size()), 32'h0);
        end

        // Back-to-back full batches every 16 clocks
        channel_enable = '1;
        b2b = 0;
        for (int c = 0; c < 67; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 65 && sample_data_avail === 1'b1) b2b++;
            if (c % 16 == 0 && c < 64) begin
                set_data(16'h1000 * 16'(c / 16 + 1));
                push_exp(16'hFFFF, 16'h1000 * 16'(c / 16 + 1), NC);
                chan_ready = '1;
            end else begin
                chan_ready = '0;
            end
        end
        chk("b2b_run", 32'(b2b), 32'd64);
        chk("b2b_tail", {31'h0, sample_data_avail}, 32'h0);
        chk("b2b_overrun", {31'h0, overrun}, 32'h0);
        chk("b2b_drained", 32'(exp_q.size()), 32'h0);

        // Overrun: second batch at E+5 is dropped
        drive_batch(16'hFFFF, 16'hFFFF, 16'hA000, NC);
        repeat (4) @(negedge clk);
        chk("ovr_before", {31'h0, overrun}, 32'h0);
        set_data(16'h5000);
        chan_ready = '1;
        @(negedge clk);
        chan_ready = '0;
        chk("ovr_set", {31'h0, overrun}, 32'h1);
        repeat (14) @(negedge clk);
        chk("ovr_sticky", {31'h0, overrun}, 32'h1);
        chk("ovr_drained", 32'(exp_q.size()), 32'h0);
        chk("ovr_idle", {31'h0, sample_data_avail}, 32'h0);
        acq_enable = 1'b0;
        @(negedge clk);
        chk("ovr_clear", {31'h0, overrun}, 32'h0);
        acq_enable = 1'b1;

        // Reset sampled at E+4: only channels 0..2 come out
        drive_batch(16'hFFFF, 16'hFFFF, 16'h7000, 3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_avail", {31'h0, sample_data_avail}, 32'h0);
        run = 0;
        repeat (18) begin
            @(negedge clk);
            if (sample_data_avail === 1'b1) run++;
        end
        chk("mid_rst_quiet", 32'(run), 32'h0);
        chk("mid_rst_drained", 32'(exp_q.size()), 32'h0);
        drive_batch(16'hFFFF, 16'hFFFF, 16'h9000, NC);
        repeat (18) @(negedge clk);
        chk("after_rst_drained", 32'(exp_q.size()), 32'h0);
        chk("after_rst_overrun", {31'h0, overrun}, 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/sample_packer.md
# sample_packer

Downstream stage of the fast clock domain's per-channel serial-to-parallel converters. It captures the 16-bit words from every enabled channel when their ready strobes fire, then serialises them onto the single `sample_data` / `sample_data_avail` stream in ascending channel order, one word per clock. It flags any batch that arrives before the previous batch has drained.

## Interface
Parameters:
- `NUM_CHANNELS`, 16: number of probe channels.
- `WORD_W`, 16: bits per channel word.

Ports:
- `clk`  in  1  fast-domain clock; single clock for the whole block.
- `rst`  in  1  reset, synchronous, active-high.
- `acq_enable`  in  1  acquisition running; captures are ignored while low.
- `channel_enable`  in  NUM_CHANNELS  per-channel enable mask.
- `chan_data`  in  NUM_CHANNELS*WORD_W  channel words, flattened; channel i occupies bits `[i*WORD_W +: WORD_W]`.
- `chan_ready`  in  NUM_CHANNELS  one-cycle strobe per channel: its word is valid.
- `sample_data`  out  WORD_W  current output word, registered.
- `sample_data_avail`  out  1  one-cycle pulse per emitted word.
- `sample_chan`  out  4  channel index of `sample_data`, registered.
- `overrun`  out  1  sticky flag: a batch was dropped.

## Operation
- Capture mask is `cap = chan_ready & channel_enable`, qualified by `acq_enable`.
- Holding registers: NUM_CHANNELS × WORD_W, plus a `pending` bit mask.
- States:
  - IDLE (`pending == 0`): a nonzero `cap` loads the words of the set channels, sets `pending = cap`, and moves to EMIT.
  - EMIT: each cycle, select the lowest set bit `k` of `pending`, then:
    - register `sample_data = hold[k]`, `sample_chan = k`, `sample_data_avail = 1`;
    - clear bit `k`.
    - When `pending` becomes 0, return to IDLE.
- Capture on the last emit cycle: if `pending` has exactly one bit set and `cap != 0` in the same cycle:
  - emit the last word;
  - load the new batch (`pending = cap`);
  - stay in EMIT.
- Overrun: `cap != 0` while in EMIT with ≥2 pending bits.
  - The new batch is dropped entirely.
  - The current batch continues unaffected.
  - `overrun` is set to 1.
- `overrun` clears only on `rst` or while `acq_enable` is 0.
- `acq_enable` falling does not abort an emission in progress; the current batch drains fully.
- Channels disabled after capture are still emitted; the mask is sampled only at capture time.
- `sample_data` and `sample_chan` hold their last value when `sample_data_avail` is 0.

## Timing
- Reset values: `sample_data = 0`, `sample_chan = 0`, `sample_data_avail = 0`, `overrun = 0`, `pending = 0`, state IDLE, holding registers 0.
- Latency: with `cap` sampled at edge E, the first word appears in the cycle after E+1. `sample_data_avail` is high from E+1 through E+n, where n = popcount(cap), with no gaps.
- Throughput: 1 word/clk. A full 16-channel batch drains in 16 cycles, which matches the fastest batch period (divisor 0: `chan_ready` every 16 clocks) with no overrun.
- `rst` asserted mid-emission: `pending` is cleared and `sample_data_avail` is 0 on the next cycle; the remaining words are lost.
- `cap` with no bits set (all strobed channels disabled): no state change.

## Structure
- Shared package `la_pkg`:
  - `NUM_CHANNELS`, `WORD_W`;
  - channel-index width `CHAN_IDX_W = $clog2(NUM_CHANNELS)`;
  - state enum {IDLE, EMIT}.
- Sub-module `lowest_set_bit` (combinational, NUM_CHANNELS-bit input): outputs the index of the lowest set bit and a `valid` flag. It is reused for the pending-mask walk.
- Everything else (holding registers, FSM, overrun logic) lives in `sample_packer`.

## Test plan
- Reset: hold `rst` for 3 clocks with random inputs → every output is 0 and `sample_data_avail` never pulses.
- Full batch: all channels enabled, channel i data = 16'hA000+i, single `chan_ready = 16'hFFFF` at E → `sample_data` 16'hA000..16'hA00F with `sample_chan` 0..15 on E+1..E+16; `overrun` stays 0.
- Sparse mask: `channel_enable = 16'h8421`, `chan_ready = 16'hFFFF` → exactly 4 words from channels 0, 5, 10, 15 in that order, on consecutive cycles.
- Back-to-back at max rate: `chan_ready = 16'hFFFF` every 16 clocks for 4 batches → 64 contiguous avail cycles, correct data, `overrun = 0`.
- Overrun: batch at E, second batch at E+5 → first batch's 16 words are emitted intact and second batch is absent; `overrun = 1` from E+6 until `acq_enable` is lowered.
- Reset mid-emission: `rst` at E+4 of a full batch → `sample_data_avail = 0` from E+5 on; a new batch after reset is emitted normally.
